// File: rtl/idct_pkg.sv
// Shared constants, FSM states and cosine/weight helpers for the 8x8 inverse DCT.
package idct_pkg;

    localparam int W_COS  = 9;
    localparam int W_TERM = 34;
    localparam int W_SUM  = 40;
    localparam int W_PIX  = 17;

    localparam int PIX_MIN = -256;
    localparam int PIX_MAX = 255;

    localparam logic signed [W_COS-1:0] ALPHA0 = 9'sd91;
    localparam logic signed [W_COS-1:0] ALPHAN = 9'sd128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Q1.8 cos((2x+1)u*pi/16), folded onto the first quarter wave; 1.0 is stored as 255.
    function automatic logic signed [W_COS-1:0] cos_q18(input logic [2:0] x, input logic [2:0] u);
        logic [6:0] prod;
        logic [4:0] m;
        logic neg;
        logic signed [W_COS-1:0] mag;
        prod = 7'({x, 1'b1}) * 7'(u);
        m    = prod[4:0];
        neg  = 1'b0;
        if (m > 5'd16) m = ~m + 5'd1;
        if (m > 5'd8) begin
            neg = 1'b1;
            m   = 5'd16 - m;
        end
        case (m)
            5'd0:    mag = 9'sd255;
            5'd1:    mag = 9'sd251;
            5'd2:    mag = 9'sd237;
            5'd3:    mag = 9'sd213;
            5'd4:    mag = 9'sd181;
            5'd5:    mag = 9'sd142;
            5'd6:    mag = 9'sd98;
            5'd7:    mag = 9'sd50;
            default: mag = 9'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    function automatic logic signed [W_COS-1:0] weight(input logic [2:0] x, input logic [2:0] u);
        logic signed [17:0] p;
        p = 18'(u == 3'd0 ? ALPHA0 : ALPHAN) * 18'(cos_q18(x, u));
        return W_COS'(p >>> 8);
    endfunction

endpackage

// File: rtl/double_counter.sv
// Two nested counters (x outer, y inner) sweeping an N x N grid while go is high.
module double_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          go,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    assign done = go && (x == LAST) && (y == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            x <= '0;
            y <= '0;
        end else if (go) begin
            if (y == LAST) begin
                y <= '0;
                x <= (x == LAST) ? '0 : x + CW'(1);
            end else begin
                y <= y + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ff_en.sv
// Generic register with synchronous active-high reset to zero and load enable.
module ff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/idct_point.sv
// Combinational 64-term weighted sum for one output pixel, with round-half-up and saturation.
module idct_point import idct_pkg::*; #(
    parameter int N          = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic [N-1:0][N-1:0][COEF_WIDTH-1:0] coef,
    input  logic [2:0]                          x,
    input  logic [2:0]                          y,
    output logic [W_PIX-1:0]                    pixel
);

    localparam logic signed [W_SUM-1:0] ROUND_HALF = W_SUM'(32'sd32768);
    localparam logic signed [W_SUM-1:0] SUM_MAX    = W_SUM'(PIX_MAX);
    localparam logic signed [W_SUM-1:0] SUM_MIN    = W_SUM'(PIX_MIN);

    logic signed [W_TERM-1:0] cx, wx, wy, term;
    logic signed [W_SUM-1:0]  acc, rnd;

    always_comb begin
        acc = '0;
        cx  = '0;
        wx  = '0;
        wy  = '0;
        term = '0;
        for (int u = 0; u < N; u++) begin
            for (int v = 0; v < N; v++) begin
                cx   = W_TERM'($signed(coef[u][v]));
                wx   = W_TERM'(weight(x, 3'(u)));
                wy   = W_TERM'(weight(y, 3'(v)));
                term = cx * wx * wy;
                acc  = acc + W_SUM'(term);
            end
        end
        rnd = (acc + ROUND_HALF) >>> 16;
        if (rnd > SUM_MAX)      pixel = W_PIX'(SUM_MAX);
        else if (rnd < SUM_MIN) pixel = W_PIX'(SUM_MIN);
        else                    pixel = W_PIX'(rnd);
    end

endmodule

// File: rtl/idct_2d.sv
// 8x8 inverse DCT: snapshots a coefficient block, then writes one reconstructed pixel per cycle.
module idct_2d import idct_pkg::*; #(
    parameter int BLOCK_SIZE = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start_block,
    input  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEF_WIDTH-1:0] coef_block,
    output logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][W_PIX-1:0]      pixel_block_out,
    output logic                                                block_done
);

    logic [1:0] state_q;
    state_t     state, next_state;
    logic       capture, calc, count_done;
    logic [2:0] x, y;
    logic [W_PIX-1:0] pixel;
    logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEF_WIDTH-1:0] snapshot;

    assign state = state_t'(state_q);

    ff_en #(.W(2)) u_state (
        .clk(clk), .rst(rst), .en(1'b1), .d(next_state), .q(state_q)
    );

    ff_en #(.W(BLOCK_SIZE*BLOCK_SIZE*COEF_WIDTH)) u_snapshot (
        .clk(clk), .rst(rst), .en(capture), .d(coef_block), .q(snapshot)
    );

    double_counter #(.N(BLOCK_SIZE)) u_counter (
        .clk(clk), .rst(rst), .restart(state == IDLE), .go(calc),
        .x(x), .y(y), .done(count_done)
    );

    idct_point #(.N(BLOCK_SIZE), .COEF_WIDTH(COEF_WIDTH)) u_point (
        .coef(snapshot), .x(x), .y(y), .pixel(pixel)
    );

    // start_block only matters in IDLE; requests during CALC/DONE are dropped, not queued
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        calc       = 1'b0;
        block_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_block) begin
                    capture    = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                calc = 1'b1;
                if (count_done) next_state = DONE;
            end
            DONE: begin
                block_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < BLOCK_SIZE; gj++) begin : g_col
            ff_en #(.W(W_PIX)) u_pix (
                .clk(clk), .rst(rst),
                .en(calc && (x == 3'(gi)) && (y == 3'(gj))),
                .d(pixel), .q(pixel_block_out[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_idct_2d.sv
// Scoreboard bench for idct_2d: a real-arithmetic reference model predicts each block.
module tb_idct_2d;

    typedef logic [7:0][7:0][15:0] coef_blk_t;
    typedef logic [7:0][7:0][16:0] pix_blk_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      start_block;
    coef_blk_t coef_block;
    pix_blk_t  pixel_block_out;
    logic      block_done;

    int        cyc = 0;
    int        errors = 0;
    int        checks = 0;
    pix_blk_t  exp_q[$];
    int        due_q[$];
    pix_blk_t  shown;

    idct_2d #(.BLOCK_SIZE(8), .COEF_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_block(start_block), .coef_block(coef_block),
        .pixel_block_out(pixel_block_out), .block_done(block_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cos_ref(int x, int u);
        real r;
        int  v;
        r = 256.0 * $cos(real'((2 * x + 1) * u) * 3.14159265358979 / 16.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic pix_blk_t model(coef_blk_t c);
        int       w[8][8];
        longint   s, r;
        pix_blk_t m;
        for (int x = 0; x < 8; x++)
            for (int u = 0; u < 8; u++)
                w[x][u] = (((u == 0) ? 91 : 128) * cos_ref(x, u)) >>> 8;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                s = 0;
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        s += longint'($signed(c[u][v])) * w[x][u] * w[y][v];
                r = (s + 32768) >>> 16;
                if (r > 255)  r = 255;
                if (r < -256) r = -256;
                m[x][y] = 17'(r);
            end
        end
        return m;
    endfunction

    function automatic coef_blk_t rand_blk(int amp);
        coef_blk_t c;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++)
                c[u][v] = 16'(int'($urandom_range(2 * amp, 0)) - amp);
        return c;
    endfunction

    task automatic check_output(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every block_done pops one predicted block and its due cycle
    always @(negedge clk) begin : monitor
        pix_blk_t e;
        int       due;
        if (block_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected block_done at cycle %0d: got 1, expected 0", cyc);
            end else begin
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                check_output("block_done cycle", cyc, due);
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++)
                        check_output($sformatf("pixel[%0d][%0d]", x, y),
                                     int'($signed(pixel_block_out[x][y])), int'($signed(e[x][y])));
            end
        end
    end

    task automatic apply_stimulus(input coef_blk_t c, input bit disturb, input int reset_at);
        int       s;
        pix_blk_t e;
        @(negedge clk);
        coef_block  = c;
        start_block = 1'b1;
        @(negedge clk);
        start_block = 1'b0;
        s = cyc;
        e = model(c);
        if (reset_at == 0) begin
            exp_q.push_back(e);
            due_q.push_back(s + 64);
        end
        for (int rel = 1; rel <= 70; rel++) begin
            if (rel > 1) @(negedge clk);
            if (reset_at == 0 && rel == 1)
                check_output("pixel[0][0] before write", int'($signed(pixel_block_out[0][0])), int'($signed(shown[0][0])));
            if (reset_at == 0 && rel == 2)
                check_output("pixel[0][0] first write", int'($signed(pixel_block_out[0][0])), int'($signed(e[0][0])));
            if (reset_at == 0 && rel == 64)
                check_output("pixel[7][7] before write", int'($signed(pixel_block_out[7][7])), int'($signed(shown[7][7])));
            if (disturb && rel == 5)  coef_block = rand_blk(32767);
            if (disturb && rel == 10) start_block = 1'b1;
            if (disturb && rel == 11) start_block = 1'b0;
            if (reset_at != 0 && rel == reset_at) rst = 1'b1;
            if (reset_at != 0 && rel == reset_at + 1) begin
                check_output("pixels nonzero after reset", int'(pixel_block_out != '0), 0);
                check_output("block_done after reset", int'(block_done), 0);
                rst   = 1'b0;
                shown = '0;
            end
        end
        if (reset_at == 0) shown = e;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        coef_blk_t c;
        rst         = 1'b1;
        start_block = 1'b0;
        coef_block  = '0;
        shown       = '0;
        repeat (3) @(negedge clk);
        check_output("reset pixels nonzero", int'(pixel_block_out != '0), 0);
        check_output("reset block_done", int'(block_done), 0);
        rst = 1'b0;

        c = '0;
        apply_stimulus(c, 1'b0, 0);

        c = '0; c[0][0] = 16'sd1024;
        apply_stimulus(c, 1'b0, 0);
        check_output("dc1024 pixel[4][2]", int'($signed(pixel_block_out[4][2])), 127);

        c = '0; c[0][0] = 16'sd4096;
        apply_stimulus(c, 1'b0, 0);
        check_output("dc4096 pixel[6][1]", int'($signed(pixel_block_out[6][1])), 255);

        c = '0; c[0][0] = -16'sd4096;
        apply_stimulus(c, 1'b0, 0);
        check_output("dc-4096 pixel[2][7]", int'($signed(pixel_block_out[2][7])), -256);

        c = '0; c[0][1] = 16'sd1024;
        apply_stimulus(c, 1'b0, 0);

        apply_stimulus(rand_blk(200), 1'b1, 0);
        apply_stimulus(rand_blk(200), 1'b0, 30);
        apply_stimulus(rand_blk(200), 1'b0, 0);
        apply_stimulus(rand_blk(64), 1'b0, 0);
        apply_stimulus(rand_blk(1000), 1'b0, 0);
        apply_stimulus(rand_blk(32767), 1'b0, 0);

        repeat (5) @(negedge clk);
        check_output("blocks outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
